// File: rtl/lfsr_pkg.sv
// Shared constants and the single-step function for the Fibonacci LFSR.
// Tap masks mark which state bits feed the XOR feedback into bit 0.
package lfsr_pkg;

  localparam int LFSR_MAX_WIDTH = 64;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  localparam logic [15:0] LFSR_SEED_16 = 16'hACE1;

  // One Fibonacci step on a zero-extended state: shift toward the MSB and
  // insert the parity of the tapped bits at bit 0. Bits at or above width
  // are masked off so the 64-bit carrier never leaks into the result.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_step(
    input logic [LFSR_MAX_WIDTH-1:0] state,
    input logic [LFSR_MAX_WIDTH-1:0] taps,
    input int                        width
  );
    logic [LFSR_MAX_WIDTH-1:0] mask;
    logic                      fb;
    mask = {LFSR_MAX_WIDTH{1'b1}} >> (LFSR_MAX_WIDTH - width);
    fb   = ^(state & taps & mask);
    return ((state << 1) | {{(LFSR_MAX_WIDTH-1){1'b0}}, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_prng_step_net.sv
// Combinational next-state network: STEP chained single LFSR steps.
// Pure logic, no state; the top samples the result on a transfer.
module lfsr_step_net
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_16,
  parameter int               STEP  = 1
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_out
);

  localparam logic [LFSR_MAX_WIDTH-1:0] TAPS_EXT = LFSR_MAX_WIDTH'(TAPS);

  logic [LFSR_MAX_WIDTH-1:0] acc;

  // Unrolled chain of STEP single steps, evaluated within one cycle.
  always_comb begin
    acc = '0;
    acc[WIDTH-1:0] = state_in;
    for (int i = 0; i < STEP; i++) begin
      acc = lfsr_step(acc, TAPS_EXT, WIDTH);
    end
    state_out = acc[WIDTH-1:0];
  end

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR source with valid/ready output, runtime reseed
// and multi-bit step per transfer. A zero seed is replaced by SEED and flagged
// with a one-cycle zero_seed_err pulse, so the all-zero lock-up state can
// never be entered.
// Optional build macro LFSR_PERIOD_CNT_EN adds period_done / period_cnt,
// which count transfers since the last seed and flag a return to that seed.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_16,
  parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_16,
  parameter int               STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             zero_seed_err
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic             period_done,
  output logic [WIDTH-1:0] period_cnt
`endif
);

  if (WIDTH < 3 || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be within 3..64");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_prng: SEED must be non-zero");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_prng: STEP must be within 1..WIDTH");
  end

  logic [WIDTH-1:0] state_q, state_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] seed_eff;
  logic             seed_zero;
  logic             fire;

  lfsr_step_net #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_step_net (
    .state_in  (state_q),
    .state_out (stepped)
  );

  assign fire      = valid_q & out_ready;
  assign seed_zero = (seed_data == '0);
  assign seed_eff  = seed_zero ? SEED : seed_data;

  // Next state: a seed load overrides a transfer; otherwise step on fire.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b1;
    err_d   = 1'b0;
    if (seed_valid) begin
      state_d = seed_eff;
      err_d   = seed_zero;
    end else if (fire) begin
      state_d = stepped;
    end
  end

  // State, valid and error-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_data      = state_q;
  assign out_valid     = valid_q;
  assign zero_seed_err = err_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             done_q, done_d;

  // Period tracking: compare each post-transfer state with the last seed.
  always_comb begin
    cnt_d  = cnt_q;
    ref_d  = ref_q;
    done_d = 1'b0;
    if (seed_valid) begin
      cnt_d = '0;
      ref_d = seed_eff;
    end else if (fire) begin
      if (stepped == ref_q) begin
        done_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Period counter registers; reset re-captures SEED as the reference.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      ref_q  <= SEED;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ref_q  <= ref_d;
      done_q <= done_d;
    end
  end

  assign period_done = done_q;
  assign period_cnt  = cnt_q;
`endif

endmodule
